// File: rtl/sram_mbist.sv
// sram_mbist: March C- self-test controller that owns an SRAM port set while busy.
// Every read is checked against its background and the first miss is captured.
module sram_mbist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] A_TOP = '1;
  localparam logic [ADDR_W-1:0] A_BOT = '0;

  logic [1:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ph_q, ph_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [2:0]        felem_q, felem_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pbg_q;
  logic [2:0]        pel_q [RD_LAT];
  logic [ADDR_W-1:0] pad_q [RD_LAT];

  logic run, pair, desc, last;
  logic wr_op, rd_op, rd_bg, wr_bg, hit;

  assign run   = (state_q == S_RUN);
  assign pair  = (elem_q != 3'd0) && (elem_q != 3'd5);
  assign desc  = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last  = desc ? (addr_q == A_BOT)
                      : (addr_q == A_TOP);
  assign wr_op = (elem_q == 3'd0) || (pair && ph_q);
  assign rd_op = (elem_q != 3'd0) && !(pair && ph_q);
  assign rd_bg = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign wr_bg = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign hit   = pv_q[RD_LAT-1] &&
                 (mem_dout != {DATA_W{pbg_q[RD_LAT-1]}});

  assign busy      = run || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_addr = faddr_q;
  assign fail_elem = felem_q;
  assign fail_data = fdata_q;
  assign mem_we    = run && wr_op;
  assign mem_addr  = addr_q;
  // elem_q parks on M5 after a run, so din keeps M4's w0 value
  assign mem_din   = {DATA_W{wr_bg}};

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    faddr_d = faddr_q;
    felem_d = felem_q;
    fdata_d = fdata_q;
    if (hit && !err_q) begin
      err_d   = 1'b1;
      faddr_d = pad_q[RD_LAT-1];
      felem_d = pel_q[RD_LAT-1];
      fdata_d = mem_dout;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = A_BOT;
          ph_d    = 1'b0;
          err_d   = 1'b0;
          pass_d  = 1'b0;
          faddr_d = '0;
          felem_d = '0;
          fdata_d = '0;
        end
      end
      S_RUN: begin
        if (pair && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (!last) begin
            addr_d = desc ? addr_q - 1'b1
                          : addr_q + 1'b1;
          end else if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
            cnt_d   = 2'(RD_LAT - 1);
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = (elem_q == 3'd2 || elem_q == 3'd3)
                     ? A_TOP : A_BOT;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == 2'd0) begin
          state_d = S_DONE;
          pass_d  = ~err_d;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      elem_q  <= 3'd0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      pass_q  <= 1'b0;
      faddr_q <= '0;
      felem_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      faddr_q <= faddr_d;
      felem_q <= felem_d;
      fdata_q <= fdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q  <= '0;
      pbg_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pel_q[i] <= '0;
        pad_q[i] <= '0;
      end
    end else begin
      pv_q[0]  <= run && rd_op;
      pbg_q[0] <= rd_bg;
      pel_q[0] <= elem_q;
      pad_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pbg_q[i] <= pbg_q[i-1];
        pel_q[i] <= pel_q[i-1];
        pad_q[i] <= pad_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_mbist.sv
// tb_sram_mbist: two controllers (read latency 1 and 3) on faulty SRAM models,
// checked against an algorithmic March C- reference run.
module tb_sram_mbist;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic       busy1, done1, pass1, we1;
  logic [3:0] fa1, ad1;
  logic [2:0] fe1;
  logic [7:0] fd1, di1, do1;
  logic       busy3, done3, pass3, we3;
  logic [3:0] fa3, ad3;
  logic [2:0] fe3;
  logic [7:0] fd3, di3, do3;

  logic [7:0] sa0 [N];
  logic [7:0] sa1 [N];
  bit         alias_en;
  logic [7:0] m1 [N];
  logic [7:0] m3 [N];
  logic [7:0] p3 [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_mbist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fa1), .fail_elem(fe1), .fail_data(fd1),
    .mem_we(we1), .mem_addr(ad1), .mem_din(di1),
    .mem_dout(do1)
  );

  sram_mbist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy3), .done(done3), .pass(pass3),
    .fail_addr(fa3), .fail_elem(fe3), .fail_data(fd3),
    .mem_we(we3), .mem_addr(ad3), .mem_din(di3),
    .mem_dout(do3)
  );

  initial begin
    for (int i = 0; i < N; i++) begin
      m1[i] = '0;
      m3[i] = '0;
      sa0[i] = '0;
      sa1[i] = '0;
    end
    for (int i = 0; i < 3; i++) p3[i] = '0;
    alias_en = 0;
  end

  always @(posedge clk) begin
    if (we1) begin
      m1[ad1] <= di1;
      if (alias_en && ad1 == 4'hA) m1[2] <= di1;
    end
    do1 <= (m1[ad1] & ~sa0[ad1]) | sa1[ad1];
  end

  always @(posedge clk) begin
    if (we3) begin
      m3[ad3] <= di3;
      if (alias_en && ad3 == 4'hA) m3[2] <= di3;
    end
    p3[0] <= (m3[ad3] & ~sa0[ad3]) | sa1[ad3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign do3 = p3[2];

  function automatic logic [7:0] rbg(input int el);
    return (el == 2 || el == 4) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] wbg(input int el);
    return (el == 1 || el == 3) ? 8'hFF : 8'h00;
  endfunction

  // Plays March C- over an abstract faulty array
  task automatic model(output bit p, output logic [3:0] fa,
                       output logic [2:0] fe, output logic [7:0] fd,
                       output int nw);
    logic [7:0] m [N];
    logic [7:0] v;
    bit e;
    int a;
    e = 0; fa = '0; fe = '0; fd = '0; nw = 0;
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k < N; k++) begin
        a = (el == 3 || el == 4) ? N - 1 - k : k;
        if (el != 0) begin
          v = (m[a] & ~sa0[a]) | sa1[a];
          if (v !== rbg(el) && !e) begin
            e = 1; fa = a[3:0]; fe = el[2:0]; fd = v;
          end
        end
        if (el != 5) begin
          m[a] = wbg(el);
          nw++;
          if (alias_en && a == 10) m[2] = wbg(el);
        end
      end
    end
    p = !e;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
    end
    alias_en = 0;
  endtask

  task automatic run_check(input string nm);
    int b1, b3, w1, w3, d1, d3, cyc, ew;
    bit ep;
    logic [3:0] ea;
    logic [2:0] ee;
    logic [7:0] ed;
    model(ep, ea, ee, ed, ew);
    b1 = 0; b3 = 0; w1 = 0; w3 = 0;
    d1 = 0; d3 = 0; cyc = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (cyc < 400 && !(d1 > 0 && d3 > 0)) begin
      b1 += int'(busy1); b3 += int'(busy3);
      w1 += int'(we1);   w3 += int'(we3);
      d1 += int'(done1); d3 += int'(done3);
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc >= 400) begin
      n_bad++;
      $display("FAIL %s timeout after %0d cycles", nm, cyc);
    end
    n_cmp++;
    if (b1 !== 10*N+1) begin
      n_bad++;
      $display("FAIL %s busy1 got %0d want %0d", nm, b1, 10*N+1);
    end
    n_cmp++;
    if (b3 !== 10*N+3) begin
      n_bad++;
      $display("FAIL %s busy3 got %0d want %0d", nm, b3, 10*N+3);
    end
    n_cmp++;
    if (w1 !== ew || w3 !== ew) begin
      n_bad++;
      $display("FAIL %s writes got %0d/%0d want %0d", nm, w1, w3, ew);
    end
    n_cmp++;
    if (d1 !== 1 || d3 !== 1) begin
      n_bad++;
      $display("FAIL %s done pulses got %0d/%0d want 1", nm, d1, d3);
    end
    n_cmp++;
    if (pass1 !== ep || pass3 !== ep) begin
      n_bad++;
      $display("FAIL %s pass got %b/%b want %b", nm, pass1, pass3, ep);
    end
    n_cmp++;
    if (fa1 !== ea || fa3 !== ea) begin
      n_bad++;
      $display("FAIL %s fail_addr got %h/%h want %h", nm, fa1, fa3, ea);
    end
    n_cmp++;
    if (fe1 !== ee || fe3 !== ee) begin
      n_bad++;
      $display("FAIL %s fail_elem got %0d/%0d want %0d", nm, fe1, fe3, ee);
    end
    n_cmp++;
    if (fd1 !== ed || fd3 !== ed) begin
      n_bad++;
      $display("FAIL %s fail_data got %h/%h want %h", nm, fd1, fd3, ed);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy1, done1, pass1, we1, fa1, fe1, fd1, ad1, di1} !== '0) begin
      n_bad++;
      $display("FAIL reset dut1 outputs got %b want 0",
               {busy1, done1, pass1, we1, fa1, fe1, fd1, ad1, di1});
    end
    n_cmp++;
    if ({busy3, done3, pass3, we3, fa3, fe3, fd3, ad3, di3} !== '0) begin
      n_bad++;
      $display("FAIL reset dut3 outputs got %b want 0",
               {busy3, done3, pass3, we3, fa3, fe3, fd3, ad3, di3});
    end
    rst = 0;
  endtask

  task automatic test_fault_free();
    clear_faults();
    run_check("fault_free");
  endtask

  task automatic test_stuck_at();
    clear_faults();
    sa0[5] = 8'h08;
    run_check("sa0_w5_b3");
    n_cmp++;
    if (fa1 !== 4'd5 || fe1 !== 3'd2 || fd1 !== 8'hF7) begin
      n_bad++;
      $display("FAIL sa0_fixed got %h/%0d/%h want 5/2/f7", fa1, fe1, fd1);
    end
  endtask

  task automatic test_decoder_alias();
    clear_faults();
    alias_en = 1;
    run_check("alias_a_to_2");
    n_cmp++;
    if (pass1 !== 1'b0 || fa1 !== 4'd2) begin
      n_bad++;
      $display("FAIL alias_addr got pass=%b addr=%h want 0/2", pass1, fa1);
    end
  endtask

  task automatic test_lat3_word15();
    clear_faults();
    sa1[15] = 8'h01;
    run_check("sa1_w15");
    n_cmp++;
    if (fa3 !== 4'd15 || pass3 !== 1'b0) begin
      n_bad++;
      $display("FAIL lat3_w15 got addr=%h pass=%b want f/0", fa3, pass3);
    end
  endtask

  task automatic test_random_faults();
    int w, b;
    for (int it = 0; it < 5; it++) begin
      clear_faults();
      w = $urandom_range(0, N-1);
      b = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) sa1[w][b] = 1'b1;
      else sa0[w][b] = 1'b1;
      if ($urandom_range(0, 3) == 0) sa0[$urandom_range(0, N-1)] = 8'h80;
      run_check($sformatf("rand%0d_w%0d_b%0d", it, w, b));
    end
  endtask

  task automatic test_reset_mid_run();
    clear_faults();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (89) @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b1 || busy3 !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_busy got %b/%b want 1", busy1, busy3);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({busy1, we1, busy3, we3} !== 4'b0) begin
      n_bad++;
      $display("FAIL async_drop got %b want 0000", {busy1, we1, busy3, we3});
    end
    n_cmp++;
    if ({done1, pass1, fa1, fe1, fd1, ad1, di1} !== '0) begin
      n_bad++;
      $display("FAIL async_vals got %b want 0",
               {done1, pass1, fa1, fe1, fd1, ad1, di1});
    end
    @(negedge clk); rst = 0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({pass1, fd1, fa1, pass3, fd3, fa3} !== '0) begin
      n_bad++;
      $display("FAIL post_rst_idle got %b want 0",
               {pass1, fd1, fa1, pass3, fd3, fa3});
    end
    run_check("after_reset");
  endtask

  task automatic test_back_to_back();
    int b1, cyc, gap;
    bit seen;
    clear_faults();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    b1 = 0; cyc = 0;
    while (cyc < 400 && !done1) begin
      b1 += int'(busy1);
      if (cyc == 38) start = 1;
      if (cyc == 39) start = 0;
      if (cyc == 150) start = 1;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (b1 !== 10*N+1) begin
      n_bad++;
      $display("FAIL b2b_first busy got %0d want %0d", b1, 10*N+1);
    end
    gap = 0; seen = 0;
    while (gap < 4 && !seen) begin
      @(negedge clk);
      gap++;
      seen = busy1;
    end
    n_cmp++;
    if (!seen || gap > 2) begin
      n_bad++;
      $display("FAIL b2b_restart got gap=%0d seen=%b want <=2/1", gap, seen);
    end
    start = 0;
    cyc = 0;
    while (cyc < 400 && !done1) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!done1 || pass1 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second got done=%b pass=%b want 1/1", done1, pass1);
    end
    cyc = 0;
    while (cyc < 400 && (busy1 || busy3 || done3)) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_decoder_alias();
    test_lat3_word15();
    test_random_faults();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
